// File: rtl/jtag_ram_pkg.sv
`default_nettype none
//==============================================================================
// Module   : jtag_ram_pkg
// Brief    : Shared opcode/state types and command/response field positions
//            for the JTAG-to-RAM bridge.
// Revision : 1.0 - initial release
//==============================================================================
package jtag_ram_pkg;

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_WRITE     = 2'b01,
        OP_READ      = 2'b10,
        OP_WRITE_INC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int c_CMD_OP_MSB    = 15;
    localparam int c_CMD_OP_LSB    = 14;
    localparam int c_CMD_ADDR_MSB  = 13;
    localparam int c_CMD_ADDR_LSB  = 8;
    localparam int c_CMD_DATA_MSB  = 7;
    localparam int c_CMD_DATA_LSB  = 0;

    localparam int c_RSP_OVR_BIT   = 15;
    localparam int c_RSP_ERR_BIT   = 14;
    localparam int c_RSP_ADDR_MSB  = 13;
    localparam int c_RSP_ADDR_LSB  = 8;
    localparam int c_RSP_DATA_MSB  = 7;
    localparam int c_RSP_DATA_LSB  = 0;

    function automatic op_e cmd_op(input logic [15:0] word);
        return op_e'(word[c_CMD_OP_MSB:c_CMD_OP_LSB]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_ram_bridge_toggle_sync.sv
`default_nettype none
//==============================================================================
// Module   : toggle_sync
// Brief    : Level-toggle synchroniser with reference flop; emits a one-cycle
//            pulse per toggle, suppressed while arming after reset.
// Revision : 1.0 - initial release
//==============================================================================
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic toggle_in,
    output logic evt_pulse
);

    localparam int                 c_ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [c_ARM_W-1:0] c_ARM_DONE = c_ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ref;
    logic [c_ARM_W-1:0]     r_arm_cnt;
    logic                   w_armed;

    assign w_armed   = (r_arm_cnt == c_ARM_DONE);
    assign evt_pulse = w_armed & (r_sync[SYNC_STAGES-1] ^ r_ref);

    // The reference flop tracks the synchroniser every cycle, so a level that
    // is already set at reset release is absorbed during arming.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync    <= '0;
            r_ref     <= 1'b0;
            r_arm_cnt <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], toggle_in};
            r_ref  <= r_sync[SYNC_STAGES-1];
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_ram_bridge.sv
`default_nettype none
//==============================================================================
// Module   : jtag_ram_bridge
// Brief    : Executes JTAG-loaded commands against a single-port RAM and
//            publishes a capture-safe response word. Optional auto-increment
//            pointer for WRITE_INC enabled by `define JTAG_RAM_AUTOINC_EN.
// Revision : 1.0 - initial release
//==============================================================================
module jtag_ram_bridge
    import jtag_ram_pkg::*;
#(
    parameter int AW          = 6,
    parameter int RW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [15:0]   cmd_word,
    input  logic          cmd_toggle,
    output logic [AW-1:0] ram_addr,
    output logic [RW-1:0] ram_data,
    output logic          ram_wren,
    output logic          ram_rden,
    input  logic [RW-1:0] ram_q,
    output logic [15:0]   rsp_word,
    output logic          busy,
    output logic [15:0]   cmd_count
);

    state_e        r_state;
    state_e        w_next;
    logic [15:0]   r_cmd;
    logic [RW-1:0] r_rd_data;
    logic          r_ovr_pend;
    logic          w_event;
    logic          w_capture;
    logic          w_drop;
    logic          w_ovr;
    op_e           w_cap_op;
    op_e           w_cmd_op;

    toggle_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_toggle_sync (
        .clk       (clk),
        .resetn    (resetn),
        .toggle_in (cmd_toggle),
        .evt_pulse (w_event)
    );

    assign w_cap_op  = cmd_op(cmd_word);
    assign w_cmd_op  = cmd_op(r_cmd);
    assign busy      = (r_state != ST_IDLE);
    assign w_capture = w_event && (r_state == ST_IDLE);
    assign w_drop    = w_event && (r_state != ST_IDLE);
    assign w_ovr     = r_ovr_pend | w_drop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_event) w_next = ST_EXEC;
            ST_EXEC: w_next = (w_cmd_op == OP_READ) ? ST_WAIT : ST_DONE;
            ST_WAIT: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef JTAG_RAM_AUTOINC_EN
    logic [AW-1:0] r_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (w_capture && (w_cap_op == OP_WRITE || w_cap_op == OP_READ)) begin
            r_ptr <= AW'(cmd_word[c_CMD_ADDR_MSB:c_CMD_ADDR_LSB]);
        end else if (r_state == ST_EXEC && w_cmd_op == OP_WRITE_INC) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end
`endif

    // Strobes are loaded on the capture edge and cleared on the next one, so
    // they are high for exactly the EXEC cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cmd    <= '0;
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b0;
            ram_rden <= 1'b0;
        end else if (w_capture) begin
            r_cmd <= cmd_word;
            case (w_cap_op)
                OP_WRITE: begin
                    ram_addr <= AW'(cmd_word[c_CMD_ADDR_MSB:c_CMD_ADDR_LSB]);
                    ram_data <= RW'(cmd_word[c_CMD_DATA_MSB:c_CMD_DATA_LSB]);
                    ram_wren <= 1'b1;
                end
                OP_READ: begin
                    ram_addr <= AW'(cmd_word[c_CMD_ADDR_MSB:c_CMD_ADDR_LSB]);
                    ram_rden <= 1'b1;
                end
`ifdef JTAG_RAM_AUTOINC_EN
                OP_WRITE_INC: begin
                    ram_addr <= r_ptr;
                    ram_data <= RW'(cmd_word[c_CMD_DATA_MSB:c_CMD_DATA_LSB]);
                    ram_wren <= 1'b1;
                end
`endif
                default: ;
            endcase
        end else begin
            ram_wren <= 1'b0;
            ram_rden <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_data <= '0;
        end else if (r_state == ST_WAIT) begin
            r_rd_data <= ram_q;
        end
    end

    // Overruns seen mid-command are parked and folded in at DONE so that the
    // response word only ever moves as a complete update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_word   <= '0;
            cmd_count  <= '0;
            r_ovr_pend <= 1'b0;
        end else if (r_state == ST_DONE) begin
            cmd_count  <= cmd_count + 16'd1;
            r_ovr_pend <= 1'b0;
            case (w_cmd_op)
                OP_NOP: begin
                    rsp_word[c_RSP_OVR_BIT] <= w_ovr;
                    rsp_word[c_RSP_ERR_BIT] <= 1'b0;
                end
                OP_WRITE: begin
                    rsp_word[c_RSP_OVR_BIT] <= rsp_word[c_RSP_OVR_BIT] | w_ovr;
                    rsp_word[c_RSP_ADDR_MSB:c_RSP_ADDR_LSB] <= 6'(ram_addr);
                    rsp_word[c_RSP_DATA_MSB:c_RSP_DATA_LSB] <= r_cmd[c_CMD_DATA_MSB:c_CMD_DATA_LSB];
                end
                OP_READ: begin
                    rsp_word[c_RSP_OVR_BIT] <= rsp_word[c_RSP_OVR_BIT] | w_ovr;
                    rsp_word[c_RSP_ADDR_MSB:c_RSP_ADDR_LSB] <= r_cmd[c_CMD_ADDR_MSB:c_CMD_ADDR_LSB];
                    rsp_word[c_RSP_DATA_MSB:c_RSP_DATA_LSB] <= 8'(r_rd_data);
                end
                default: begin
                    rsp_word[c_RSP_OVR_BIT] <= rsp_word[c_RSP_OVR_BIT] | w_ovr;
`ifdef JTAG_RAM_AUTOINC_EN
                    rsp_word[c_RSP_ADDR_MSB:c_RSP_ADDR_LSB] <= 6'(ram_addr);
                    rsp_word[c_RSP_DATA_MSB:c_RSP_DATA_LSB] <= r_cmd[c_CMD_DATA_MSB:c_CMD_DATA_LSB];
`else
                    rsp_word[c_RSP_ERR_BIT] <= 1'b1;
`endif
                end
            endcase
        end else if (w_drop) begin
            r_ovr_pend <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_ram_bridge.sv
`default_nettype none
//==============================================================================
// Module   : tb_jtag_ram_bridge
// Brief    : Directed bench for jtag_ram_bridge with a command-level model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_jtag_ram_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] cmd_word = '0;
    logic        cmd_toggle = 1'b0;
    logic [5:0]  ram_addr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic        ram_rden;
    logic [7:0]  ram_q;
    logic [15:0] rsp_word;
    logic        busy;
    logic [15:0] cmd_count;

    always #5 clk = ~clk;

    jtag_ram_bridge #(
        .AW          (6),
        .RW          (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_word   (cmd_word),
        .cmd_toggle (cmd_toggle),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_rden   (ram_rden),
        .ram_q      (ram_q),
        .rsp_word   (rsp_word),
        .busy       (busy),
        .cmd_count  (cmd_count)
    );

    // Synchronous RAM attached to the bridge
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Command-level model: each command yields one response/count update at a
    // fixed cycle after its toggle, plus an expected strobe in its EXEC cycle.
    logic [15:0] m_rsp = '0;
    logic [15:0] m_count = '0;
    logic [5:0]  m_ptr = '0;
    logic [7:0]  m_mem [64];
    bit          p_valid = 1'b0;
    int          p_at = 0;
    logic [15:0] p_rsp = '0;
    logic [15:0] p_count = '0;
    int          b_lo = -100;
    int          b_hi = -100;
    int          e_exec = -100;
    bit          e_wr = 1'b0;
    bit          e_rd = 1'b0;
    logic [5:0]  e_a = '0;
    logic [7:0]  e_d = '0;
    bit          chk_en = 1'b0;
    int          last_c0 = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (p_valid && cyc >= p_at) begin
                m_rsp   = p_rsp;
                m_count = p_count;
                p_valid = 1'b0;
            end
            check("rsp_word", rsp_word, m_rsp);
            check("cmd_count", cmd_count, m_count);
            check("busy", 16'(busy), 16'(cyc >= b_lo && cyc < b_hi));
            check("ram_wren", 16'(ram_wren), 16'(cyc == e_exec && e_wr));
            check("ram_rden", 16'(ram_rden), 16'(cyc == e_exec && e_rd));
            if (ram_wren) begin
                check("wr_addr", 16'(ram_addr), 16'(e_a));
                check("wr_data", 16'(ram_data), 16'(e_d));
            end
            if (ram_rden) check("rd_addr", 16'(ram_addr), 16'(e_a));
        end
    end

    task automatic start_cmd(input logic [1:0] op, input logic [5:0] a,
                             input logic [7:0] d, input bit drop);
        logic [15:0] nr;
        logic        ov;
        int          lat;
        ov   = m_rsp[15] | drop;
        e_wr = 1'b0;
        e_rd = 1'b0;
        nr   = m_rsp;
        case (op)
            2'd0: nr = {drop, 1'b0, m_rsp[13:0]};
            2'd1: begin
                m_ptr = a; m_mem[a] = d;
                nr = {ov, m_rsp[14], a, d};
                e_wr = 1'b1; e_a = a; e_d = d;
            end
            2'd2: begin
                m_ptr = a;
                nr = {ov, m_rsp[14], a, m_mem[a]};
                e_rd = 1'b1; e_a = a;
            end
            default: begin
`ifdef JTAG_RAM_AUTOINC_EN
                nr = {ov, m_rsp[14], m_ptr, d};
                e_wr = 1'b1; e_a = m_ptr; e_d = d;
                m_mem[m_ptr] = d;
                m_ptr = m_ptr + 6'd1;
`else
                nr = {ov, 1'b1, m_rsp[13:0]};
`endif
            end
        endcase
        lat     = (op == 2'd2) ? 6 : 5;
        last_c0 = cyc;
        p_rsp   = nr;
        p_count = m_count + 16'd1;
        p_at    = last_c0 + lat;
        p_valid = 1'b1;
        b_lo    = last_c0 + 3;
        b_hi    = last_c0 + lat;
        e_exec  = last_c0 + 3;
        cmd_word   = {op, a, d};
        cmd_toggle = ~cmd_toggle;
        if (drop) begin
            @(negedge clk);
            cmd_toggle = ~cmd_toggle;
        end
    endtask

    task automatic finish_cmd();
        repeat (10) @(negedge clk);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] a,
                           input logic [7:0] d, input bit drop);
        start_cmd(op, a, d, drop);
        finish_cmd();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rsp", rsp_word, 16'h0000);
        check("rst_count", cmd_count, 16'h0000);
        check("rst_busy", 16'(busy), 16'h0000);
        check("rst_strobes", 16'({ram_wren, ram_rden}), 16'h0000);
        check("rst_addr_data", {2'b00, ram_addr, ram_data}, 16'h0000);
        resetn = 1'b1;
        chk_en = 1'b1;
        repeat (8) @(negedge clk);

        // Basic write
        run_cmd(2'd1, 6'h05, 8'hA5, 1'b0);
        check("w5_rsp", rsp_word, 16'h05A5);
        check("w5_count", cmd_count, 16'd1);

        // Read with exact latency: previous response held through DONE
        run_cmd(2'd1, 6'h10, 8'h3C, 1'b0);
        check("w10_rsp", rsp_word, 16'h103C);
        start_cmd(2'd2, 6'h05, 8'h00, 1'b0);
        while (cyc < last_c0 + 5) @(negedge clk);
        check("rd_pre", rsp_word, 16'h103C);
        @(negedge clk);
        check("rd_post", rsp_word, 16'h05A5);
        finish_cmd();
        check("rd_count", cmd_count, 16'd3);

        // Back-to-back toggle: second dropped, overrun sticky until NOP
        run_cmd(2'd1, 6'h20, 8'h77, 1'b1);
        check("ovr_rsp", rsp_word, 16'hA077);
        check("ovr_count", cmd_count, 16'd4);
        run_cmd(2'd0, 6'h00, 8'h00, 1'b0);
        check("nop_clr", rsp_word, 16'h2077);

        // Pointer wrap / disabled WRITE_INC
        run_cmd(2'd1, 6'h3F, 8'h11, 1'b0);
        check("w3f_rsp", rsp_word, 16'h3F11);
        run_cmd(2'd3, 6'h00, 8'h22, 1'b0);
        run_cmd(2'd3, 6'h00, 8'h22, 1'b0);
`ifdef JTAG_RAM_AUTOINC_EN
        check("winc_rsp", rsp_word, 16'h0022);
`else
        check("winc_rsp", rsp_word, 16'h7F11);
`endif
        run_cmd(2'd2, 6'h3F, 8'h00, 1'b0);
`ifdef JTAG_RAM_AUTOINC_EN
        check("rd3f_rsp", rsp_word, 16'h3F22);
`else
        check("rd3f_rsp", rsp_word, 16'h7F11);
`endif
        run_cmd(2'd0, 6'h00, 8'h00, 1'b0);
        check("nop2_count", cmd_count, 16'd10);

        // Reset during WAIT with toggle held high through release
        if (cmd_toggle) run_cmd(2'd0, 6'h00, 8'h00, 1'b0);
        start_cmd(2'd2, 6'h10, 8'h00, 1'b0);
        while (cyc < last_c0 + 4) @(negedge clk);
        check("wait_busy", 16'(busy), 16'h0001);
        #1;
        chk_en = 1'b0;
        resetn = 1'b0;
        #1;
        check("ar_rsp", rsp_word, 16'h0000);
        check("ar_count", cmd_count, 16'h0000);
        check("ar_busy_strobes", 16'({busy, ram_wren, ram_rden}), 16'h0000);
        check("ar_addr_data", {2'b00, ram_addr, ram_data}, 16'h0000);
        repeat (3) @(negedge clk);
        m_rsp   = '0;
        m_count = '0;
        m_ptr   = '0;
        p_valid = 1'b0;
        b_lo    = -100;
        b_hi    = -100;
        e_exec  = -100;
        resetn  = 1'b1;
        chk_en  = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_rsp", rsp_word, 16'h0000);
        check("post_rst_count", cmd_count, 16'h0000);

        run_cmd(2'd1, 6'h01, 8'h5C, 1'b0);
        check("post_rst_w", rsp_word, 16'h015C);
        check("post_rst_wcount", cmd_count, 16'd1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtag_ram_bridge.md
JTAG_RAM_BRIDGE -- requirements
Module: jtag_ram_bridge

Interface
REQ-001 Parameter AW, 6, RAM address width (64 words).
REQ-002 Parameter RW, 8, RAM data width.
REQ-003 Parameter SYNC_STAGES, 2, toggle synchroniser depth (min 2).
REQ-004 clk  input  1  system clock; all logic in this domain.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 cmd_word  input  16  JTAG-loaded command; quasi-static, stable for ≥SYNC_STAGES+2 clk after each cmd_toggle change.
REQ-007 cmd_toggle  input  1  level toggles once per new cmd_word, from JTAG update-DR.
REQ-008 ram_addr  output  AW  RAM address, registered.
REQ-009 ram_data  output  RW  RAM write data, registered.
REQ-010 ram_wren  output  1  one-cycle write strobe.
REQ-011 ram_rden  output  1  one-cycle read strobe.
REQ-012 ram_q  input  RW  RAM read data, valid one clk after the rden cycle.
REQ-013 rsp_word  output  16  response for JTAG capture-DR: [15] overrun, [14] error, [13:8] addr, [7:0] data.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 cmd_count  output  16  commands executed, wraps 0xFFFF->0.

Function
REQ-016 cmd_word format: [15:14] op, [13:8] addr, [7:0] data; op 00 NOP, 01 WRITE, 10 READ, 11 WRITE_INC.
REQ-017 cmd_toggle passes through SYNC_STAGES flops; an event is any difference between the synchroniser output and a reference flop, which then updates.
REQ-018 FSM states IDLE, EXEC, WAIT, DONE; IDLE->EXEC on event, capturing cmd_word into a command register in the same cycle.
REQ-019 EXEC WRITE: ram_addr=cmd addr, ram_data=cmd data, ram_wren=1 for exactly that cycle; ->DONE.
REQ-020 EXEC READ: ram_addr=cmd addr, ram_rden=1 for exactly that cycle; ->WAIT; WAIT samples ram_q at its closing edge; ->DONE.
REQ-021 EXEC NOP: no RAM strobe; ->DONE; rsp addr/data fields unchanged.
REQ-022 DONE: rsp_word[13:8] and [7:0] updated (WRITE echoes written data, READ returns ram_q), cmd_count increments; ->IDLE.
REQ-023 Latency from synchronised toggle edge to rsp_word update: WRITE/NOP 3 clk, READ 4 clk.
REQ-024 Event detected while busy: command dropped, rsp_word[15] set sticky, FSM unaffected.
REQ-025 rsp_word[15] and [14] clear only on reset or on a NOP command completing.
REQ-026 ram_wren and ram_rden never high together and never high outside EXEC.
REQ-027 rsp_word changes only in DONE so a JTAG capture mid-command sees the previous complete response.

Reset
REQ-028 Reset: FSM IDLE, synchroniser and command register 0, ram_addr/ram_data 0, ram_wren/ram_rden 0, rsp_word 0, busy 0, cmd_count 0, address pointer 0.
REQ-029 For the first SYNC_STAGES+1 clk after reset release the reference flop follows the synchroniser output with no event generated (arming).
REQ-030 Reset asserted mid-command aborts it immediately; any in-flight strobe drops asynchronously; the command is not counted.

Configuration
REQ-031 JTAG_RAM_AUTOINC_EN defined: WRITE_INC writes cmd data to the internal address pointer, then pointer increments modulo 2^AW (63->0); WRITE and READ load the pointer with cmd addr; rsp addr field reports the address written.
REQ-032 JTAG_RAM_AUTOINC_EN undefined: no pointer; WRITE_INC performs no RAM access, sets rsp_word[14], still passes through DONE and counts.

Structure
REQ-033 Package jtag_ram_pkg holds the op enum, FSM state enum, and rsp_word bit-position constants.
REQ-034 Sub-module toggle_sync (SYNC_STAGES flops + reference flop + arming) produces a one-cycle event pulse.

Verification
REQ-035 WRITE 0x4_5A5 (op01, addr 0x05, data 0xA5) + toggle -> single ram_wren cycle at addr 5, data 0xA5; rsp_word 0x05A5; cmd_count 1.
REQ-036 Preload addr 5 = 0xA5; READ 0x8500 + toggle -> one ram_rden cycle, rsp_word 0x05A5 exactly 4 clk after synchronised edge.
REQ-037 Second toggle 1 clk after first -> first executes, second dropped, rsp_word[15]=1; following NOP clears it.
REQ-038 Macro defined: WRITE addr 0x3F data 0x11, then WRITE_INC data 0x22 twice -> writes at 0x3F, 0x00; rsp addr 0x00; macro undefined: WRITE_INC gives rsp_word[14]=1, no ram_wren.
REQ-039 resetn low during WAIT -> all outputs 0 immediately; cmd_toggle held at 1 through release -> no command executed.
